// File: rtl/id_pkg.sv
// Shared encodings for the ID stage: MIPS-I opcode/funct values, one-hot
// instruction-class bit positions and destination-select masks.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam int IC_ADD   = 0;
   localparam int IC_SUB   = 1;
   localparam int IC_AND   = 2;
   localparam int IC_OR    = 3;
   localparam int IC_SLT   = 4;
   localparam int IC_SLTU  = 5;
   localparam int IC_ADDI  = 6;
   localparam int IC_ANDI  = 7;
   localparam int IC_ORI   = 8;
   localparam int IC_LUI   = 9;
   localparam int IC_LB    = 10;
   localparam int IC_LH    = 11;
   localparam int IC_LW    = 12;
   localparam int IC_SB    = 13;
   localparam int IC_SH    = 14;
   localparam int IC_SW    = 15;
   localparam int IC_BEQ   = 16;
   localparam int IC_BNE   = 17;
   localparam int IC_JAL   = 18;
   localparam int IC_JR    = 19;
   localparam int IC_MULT  = 20;
   localparam int IC_MULTU = 21;
   localparam int IC_DIV   = 22;
   localparam int IC_DIVU  = 23;
   localparam int IC_MFHI  = 24;
   localparam int IC_MFLO  = 25;
   localparam int IC_MTHI  = 26;
   localparam int IC_MTLO  = 27;

   localparam logic [4:0] RA = 5'd31;

   // Classes whose destination is the rd field vs. the rt field.
   localparam logic [31:0] MASK_DEST_RD =
      (32'd1 << IC_ADD) | (32'd1 << IC_SUB) | (32'd1 << IC_AND) | (32'd1 << IC_OR) |
      (32'd1 << IC_SLT) | (32'd1 << IC_SLTU) | (32'd1 << IC_MFHI) | (32'd1 << IC_MFLO);
   localparam logic [31:0] MASK_DEST_RT =
      (32'd1 << IC_ADDI) | (32'd1 << IC_ANDI) | (32'd1 << IC_ORI) | (32'd1 << IC_LUI) |
      (32'd1 << IC_LB) | (32'd1 << IC_LH) | (32'd1 << IC_LW);

   function automatic logic [31:0] onehot(input int idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 general register file: synchronous clear, one write port from
// write-back, two combinational read ports with write-back bypass.
module id_regfile
   import id_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [31:0] regs [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   function automatic logic [31:0] read_port(input logic [4:0] addr,
                                             input logic [31:0] stored);
      if (addr == 5'd0)                  return '0;
      else if (we && (waddr == addr))    return wdata;
      else                               return stored;
   endfunction

   always_comb begin
      rdata1 = read_port(raddr1, regs[raddr1]);
      rdata2 = read_port(raddr2, regs[raddr2]);
   end

endmodule

// File: rtl/id_decode_core.sv
// ID-stage core: field split, one-hot class decode, destination select,
// register file and delay-slot next-PC computation.
module id_decode_core
   import id_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] f_pc,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic [31:0] wb_pc,
   input  logic        fwd_we,
   input  logic [4:0]  fwd_addr,
   input  logic [31:0] fwd_data,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm16,
   output logic [25:0] imm26,
   output logic [31:0] iclass,
   output logic [4:0]  a3,
   output logic        rf_we,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] npc,
   output logic        w_grf_we,
   output logic [4:0]  w_grf_addr,
   output logic [31:0] w_grf_wdata,
   output logic [31:0] w_inst_addr
);

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [31:0]        op_a;
   logic [31:0]        op_b;
   logic signed [31:0] br_off;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign imm16  = instr[15:0];
   assign imm26  = instr[25:0];

   always_comb begin
      iclass = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:   iclass = onehot(IC_ADD);
               FN_SUB:   iclass = onehot(IC_SUB);
               FN_AND:   iclass = onehot(IC_AND);
               FN_OR:    iclass = onehot(IC_OR);
               FN_SLT:   iclass = onehot(IC_SLT);
               FN_SLTU:  iclass = onehot(IC_SLTU);
               FN_JR:    iclass = onehot(IC_JR);
               FN_MULT:  iclass = onehot(IC_MULT);
               FN_MULTU: iclass = onehot(IC_MULTU);
               FN_DIV:   iclass = onehot(IC_DIV);
               FN_DIVU:  iclass = onehot(IC_DIVU);
               FN_MFHI:  iclass = onehot(IC_MFHI);
               FN_MFLO:  iclass = onehot(IC_MFLO);
               FN_MTHI:  iclass = onehot(IC_MTHI);
               FN_MTLO:  iclass = onehot(IC_MTLO);
               default:  iclass = '0;
            endcase
         end
         OP_ADDI: iclass = onehot(IC_ADDI);
         OP_ANDI: iclass = onehot(IC_ANDI);
         OP_ORI:  iclass = onehot(IC_ORI);
         OP_LUI:  iclass = onehot(IC_LUI);
         OP_LB:   iclass = onehot(IC_LB);
         OP_LH:   iclass = onehot(IC_LH);
         OP_LW:   iclass = onehot(IC_LW);
         OP_SB:   iclass = onehot(IC_SB);
         OP_SH:   iclass = onehot(IC_SH);
         OP_SW:   iclass = onehot(IC_SW);
         OP_BEQ:  iclass = onehot(IC_BEQ);
         OP_BNE:  iclass = onehot(IC_BNE);
         OP_JAL:  iclass = onehot(IC_JAL);
         default: iclass = '0;
      endcase
   end

   always_comb begin
      a3    = 5'd0;
      rf_we = 1'b0;
      if (|(iclass & MASK_DEST_RD)) begin
         a3    = rd;
         rf_we = 1'b1;
      end else if (|(iclass & MASK_DEST_RT)) begin
         a3    = rt;
         rf_we = 1'b1;
      end else if (iclass[IC_JAL]) begin
         a3    = RA;
         rf_we = 1'b1;
      end
   end

   id_regfile u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_we),
      .waddr  (wb_addr),
      .wdata  (wb_data),
      .raddr1 (rs),
      .raddr2 (rt),
      .rdata1 (rd1),
      .rdata2 (rd2)
   );

   // Branch/jr operands take the EX result; rd1/rd2 themselves stay unforwarded.
   always_comb begin
      op_a = rd1;
      op_b = rd2;
      if (fwd_we && (fwd_addr == rs) && (rs != 5'd0)) op_a = fwd_data;
      if (fwd_we && (fwd_addr == rt) && (rt != 5'd0)) op_b = fwd_data;
   end

   assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

   // f_pc is already the delay-slot address, so offsets are relative to it.
   always_comb begin
      npc = f_pc + 32'd4;
      if ((iclass[IC_BEQ] && (op_a == op_b)) || (iclass[IC_BNE] && (op_a != op_b)))
         npc = f_pc + br_off;
      else if (iclass[IC_JAL])
         npc = {f_pc[31:28], imm26, 2'b00};
      else if (iclass[IC_JR])
         npc = op_a;
   end

   assign w_grf_we    = wb_we;
   assign w_grf_addr  = wb_addr;
   assign w_grf_wdata = wb_data;
   assign w_inst_addr = wb_pc;

endmodule

// File: tb/tb_id_decode_core.sv
// Directed bench for id_decode_core: decode fields, GRF write/bypass/reset,
// branch/jump next-PC and EX-forwarded branch operands.
module tb_id_decode_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, f_pc;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, wb_pc;
   logic        fwd_we;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic [4:0]  rs, rt, rd, shamt, a3;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] iclass, rd1, rd2, npc;
   logic        rf_we, w_grf_we;
   logic [4:0]  w_grf_addr;
   logic [31:0] w_grf_wdata, w_inst_addr;

   int n_vec = 0;
   int n_err = 0;

   id_decode_core dut (
      .clk(clk), .reset(reset), .instr(instr), .f_pc(f_pc),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
      .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16), .imm26(imm26),
      .iclass(iclass), .a3(a3), .rf_we(rf_we), .rd1(rd1), .rd2(rd2), .npc(npc),
      .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
      .w_inst_addr(w_inst_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grf_write(input logic [4:0] addr, input logic [31:0] data);
      wb_we = 1'b1; wb_addr = addr; wb_data = data;
      tick();
      wb_we = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; instr = '0; f_pc = 32'h3004;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
      fwd_we = 1'b0; fwd_addr = '0; fwd_data = '0;
      tick(); tick();
      reset = 1'b0;
      #1;

      // nop / reset state
      chk("nop_iclass", iclass, 32'h0);
      chk("nop_a3", {27'd0, a3}, 32'd0);
      chk("nop_rfwe", {31'd0, rf_we}, 32'd0);
      chk("nop_npc", npc, 32'h3008);
      instr = 32'h00A0_0000; #1;
      chk("reset_rd1_r5", rd1, 32'h0);

      // add $3,$1,$2
      instr = 32'h0022_1820; #1;
      chk("add_rs", {27'd0, rs}, 32'd1);
      chk("add_rt", {27'd0, rt}, 32'd2);
      chk("add_rd", {27'd0, rd}, 32'd3);
      chk("add_iclass", iclass, 32'h0000_0001);
      chk("add_a3", {27'd0, a3}, 32'd3);
      chk("add_rfwe", {31'd0, rf_we}, 32'd1);

      // ori $2,$1,0xFF
      instr = 32'h3422_00FF; #1;
      chk("ori_iclass", iclass, 32'h0000_0100);
      chk("ori_a3", {27'd0, a3}, 32'd2);
      chk("ori_imm16", {16'd0, imm16}, 32'h00FF);
      chk("ori_rfwe", {31'd0, rf_we}, 32'd1);

      // sw $2,4($1)
      instr = 32'hAC22_0004; #1;
      chk("sw_iclass", iclass, 32'h0000_8000);
      chk("sw_a3", {27'd0, a3}, 32'd0);
      chk("sw_rfwe", {31'd0, rf_we}, 32'd0);

      // lw $3,0($2), mfhi $3, mult $1,$2
      instr = 32'h8C43_0000; #1;
      chk("lw_iclass", iclass, 32'h0000_1000);
      chk("lw_a3", {27'd0, a3}, 32'd3);
      instr = 32'h0000_1810; #1;
      chk("mfhi_iclass", iclass, 32'h0100_0000);
      chk("mfhi_a3", {27'd0, a3}, 32'd3);
      instr = 32'h0022_0018; #1;
      chk("mult_iclass", iclass, 32'h0010_0000);
      chk("mult_rfwe", {31'd0, rf_we}, 32'd0);

      // GRF write $5 plus trace passthrough
      instr = 32'h00A0_0000;
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; wb_pc = 32'h0000_3000; #1;
      chk("trace_we", {31'd0, w_grf_we}, 32'd1);
      chk("trace_addr", {27'd0, w_grf_addr}, 32'd5);
      chk("trace_data", w_grf_wdata, 32'hDEAD_BEEF);
      chk("trace_pc", w_inst_addr, 32'h0000_3000);
      chk("bypass_r5", rd1, 32'hDEAD_BEEF);
      tick();
      wb_we = 1'b0; #1;
      chk("stored_r5", rd1, 32'hDEAD_BEEF);

      // write to $0 is discarded
      instr = 32'h0000_0000;
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678; #1;
      chk("r0_bypass", rd1, 32'h0);
      tick();
      wb_we = 1'b0; #1;
      chk("r0_after", rd1, 32'h0);
      chk("r0_rd2", rd2, 32'h0);

      // same-cycle write/read of $7 on both ports
      instr = 32'h00E7_0000;
      wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE_0007; #1;
      chk("r7_bypass_rd1", rd1, 32'hCAFE_0007);
      chk("r7_bypass_rd2", rd2, 32'hCAFE_0007);
      tick();
      wb_we = 1'b0; #1;
      chk("r7_stored", rd2, 32'hCAFE_0007);

      // branches at f_pc = 0x3004
      grf_write(5'd1, 32'h55);
      grf_write(5'd2, 32'h55);
      grf_write(5'd3, 32'h66);
      f_pc = 32'h3004;
      instr = 32'h1022_FFFF; #1;
      chk("beq_eq_iclass", iclass, 32'h0001_0000);
      chk("beq_eq_npc", npc, 32'h3000);
      instr = 32'h1023_FFFF; #1;
      chk("beq_ne_npc", npc, 32'h3008);
      instr = 32'h1422_FFFF; #1;
      chk("bne_eq_npc", npc, 32'h3008);
      instr = 32'h1423_FFFF; #1;
      chk("bne_ne_npc", npc, 32'h3000);
      chk("bne_rfwe", {31'd0, rf_we}, 32'd0);

      // jal / jr
      instr = 32'h0C00_0C03; #1;
      chk("jal_npc", npc, 32'h0000_300C);
      chk("jal_a3", {27'd0, a3}, 32'd31);
      chk("jal_rfwe", {31'd0, rf_we}, 32'd1);
      f_pc = 32'hA000_3004; #1;
      chk("jal_npc_hi", npc, 32'hA000_300C);
      f_pc = 32'h3004;
      grf_write(5'd31, 32'h3010);
      instr = 32'h03E0_0008; #1;
      chk("jr_iclass", iclass, 32'h0008_0000);
      chk("jr_npc", npc, 32'h3010);
      chk("jr_a3", {27'd0, a3}, 32'd0);

      // EX forwarding into branch compare: beq $4,$9,+3
      grf_write(5'd4, 32'd1);
      grf_write(5'd9, 32'd9);
      instr = 32'h1089_0003; #1;
      chk("fwd_off_npc", npc, 32'h3008);
      fwd_we = 1'b1; fwd_addr = 5'd4; fwd_data = 32'd9; #1;
      chk("fwd_rs_npc", npc, 32'h3010);
      chk("fwd_rd1_unfwd", rd1, 32'd1);
      fwd_addr = 5'd0; #1;
      chk("fwd_r0_npc", npc, 32'h3008);
      fwd_addr = 5'd9; fwd_data = 32'd1; #1;
      chk("fwd_rt_npc", npc, 32'h3010);
      chk("fwd_rd2_unfwd", rd2, 32'd9);
      fwd_we = 1'b0; #1;
      chk("fwd_we0_npc", npc, 32'h3008);

      // reset wins over a simultaneous write
      reset = 1'b1; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h7777_7777;
      tick();
      reset = 1'b0; wb_we = 1'b0; #1;
      for (int r = 1; r < 32; r++) begin
         instr = {6'd0, r[4:0], r[4:0], 16'd0}; #1;
         chk($sformatf("reset_rd1_r%0d", r), rd1, 32'h0);
         chk($sformatf("reset_rd2_r%0d", r), rd2, 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
